our_sram_port_arbiter: RTL and testbench
========================================

// Module: our_sram_port_arbiter
// PURPOSE
//  Shares the single flat SRAM port (mem_req/addr/wdata/strb/we/rdata) of the large single-port SRAM
//  among NUM_REQ requesters, e.g. the AXI 128-bit slave plus a preload/debug port.
//  Single-cycle grant with round-robin fairness; optional bounded lock keeps a burst contiguous.
//  Read data returns RD_LATENCY cycles after the grant, tagged back to the requester that issued it.
// PARAMETERS
//  NUM_REQ     2    number of requesters (2..8)
//  ADDR_WIDTH  21   SRAM word address width (128-bit words)
//  DATA_WIDTH  128  data width; strobe is a per-bit mask of the same width
//  RD_LATENCY  1    SRAM read latency in cycles (1..3)
//  MAX_HOLD    16   max consecutive grants to one locked requester while others wait
// PORTS
//  pll_core_cpuclk  in   1                     single clock, rising edge
//  pad_cpu_rst      in   1                     asynchronous, active-high reset
//  req_i            in   NUM_REQ               per-requester access request
//  lock_i           in   NUM_REQ               keep ownership for the next request (burst)
//  we_i             in   NUM_REQ               1=write, 0=read
//  addr_i           in   NUM_REQ*ADDR_WIDTH    word address per requester
//  wdata_i          in   NUM_REQ*DATA_WIDTH    write data per requester
//  strb_i           in   NUM_REQ*DATA_WIDTH    bit write mask per requester (1=write bit)
//  gnt_o            out  NUM_REQ               one-hot grant; access is accepted this cycle
//  rvalid_o         out  NUM_REQ               one-hot read-data valid
//  rdata_o          out  DATA_WIDTH            read data, broadcast; qualify with rvalid_o
//  mem_req_o        out  1                     SRAM access strobe
//  mem_we_o         out  1                     SRAM write enable
//  mem_addr_o       out  ADDR_WIDTH            SRAM address
//  mem_wdata_o      out  DATA_WIDTH            SRAM write data
//  mem_strb_o       out  DATA_WIDTH            SRAM bit mask
//  mem_rdata_i      in   DATA_WIDTH            SRAM read data, valid RD_LATENCY cycles after mem_req_o&~mem_we_o
// BEHAVIOUR
//  - Reset (pad_cpu_rst=1, async): rr_ptr=0, owner invalid, hold_cnt=0, read tag pipe cleared.
//    While reset is asserted: gnt_o=0, rvalid_o=0, mem_req_o=0, mem_we_o=0.
//    mem_addr/wdata/strb_o=0 and rdata_o=mem_rdata_i (don't-care).
//  - Grant is combinational: at most one gnt_o bit, only to a requester with req_i=1.
//    mem_* is muxed from the granted requester; mem_req_o = |gnt_o.
//  - Selection, states OPEN/LOCKED:
//    OPEN: first req_i bit at or after rr_ptr (circular). On grant: rr_ptr <= winner+1 (mod NUM_REQ).
//    If lock_i[winner], owner<=winner, go to LOCKED and hold_cnt<=1.
//    LOCKED: owner wins whenever req_i[owner]=1; others get nothing.
//    hold_cnt increments on each owner grant while any other req_i is high.
//    Cycles where the owner does not request are idle cycles (no grant to others).
//    Exit to OPEN when an owner grant has lock_i[owner]=0, or hold_cnt==MAX_HOLD with another requester waiting.
//    On the MAX_HOLD exit the owner is not granted that cycle; the round-robin winner excluding the owner is granted instead.
//  - Read return: each granted read pushes its requester index into a RD_LATENCY-deep valid/tag shift register.
//    rvalid_o[tag] is asserted exactly RD_LATENCY cycles after the grant.
//    Writes push no tag and are complete at grant.
//  - Back-to-back reads from different requesters every cycle are supported; no bubbles.
//  - Simultaneous requests from all requesters with equal priority rotate strictly.
//    For NUM_REQ=2 that is alternation 0,1,0,1.
//  - Reset mid-operation: in-flight read tags are discarded; no rvalid_o after reset deassertion for pre-reset grants.
//  - NUM_REQ=1: always grant; lock has no effect.
// STRUCTURE
//  - our_sram_pkg: typedefs sram_addr_t, sram_data_t, req_idx_t; constant SRAM_ADDR_WIDTH=21 and SRAM_DATA_WIDTH=128,
//    shared with the AXI slave and SRAM wrapper.
//  - One sub-module our_rr_pick: combinational circular priority pick (req, ptr, mask -> one-hot, index).
//  - Tag pipe and lock FSM stay inline.
// TESTING
//  - Reset: assert pad_cpu_rst with req_i=2'b11 -> gnt_o=0, mem_req_o=0; release -> first grant to req 0.
//  - Fairness: req_i=2'b11 held 6 cycles, no lock -> gnt_o sequence 01,10,01,10,01,10.
//  - Read tag: req1 reads addr 0x00010, RD_LATENCY=2 -> rvalid_o=2'b10 two cycles later, rdata_o=mem_rdata_i.
//    Next cycle req0 reads -> rvalid_o=2'b01 the following cycle.
//  - Lock/starvation: req0 lock_i=1 continuously, req1 requesting, MAX_HOLD=4 -> req0 granted 4x, then req1 granted once.
//  - Write pass-through: req0 write addr 0x1F_FFFF, wdata 128'hA5.., strb all ones -> mem_we_o=1, fields match, no rvalid_o.
//  - Reset mid-read: read granted, reset asserted before RD_LATENCY elapses -> no rvalid_o after release.

Source files
------------

// File: rtl/our_sram_pkg.sv
// Shared SRAM types and constants used by the arbiter, the AXI slave and the SRAM wrapper.
package our_sram_pkg;

    localparam int SRAM_ADDR_WIDTH = 21;
    localparam int SRAM_DATA_WIDTH = 128;

    typedef logic [SRAM_ADDR_WIDTH-1:0] sram_addr_t;
    typedef logic [SRAM_DATA_WIDTH-1:0] sram_data_t;
    // Wide enough for up to 8 requesters.
    typedef logic [2:0]                 req_idx_t;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Circular increment of a requester index.
    function automatic req_idx_t rr_next(input req_idx_t idx, input int n);
        if (int'(idx) + 1 >= n) begin
            return '0;
        end
        return idx + req_idx_t'(1);
    endfunction

endpackage

// File: rtl/our_rr_pick.sv
// Combinational circular priority pick: first set bit of (req & mask) at or after ptr.
module our_rr_pick
    import our_sram_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  req_idx_t     ptr,
    output logic [N-1:0] onehot,
    output req_idx_t     idx,
    output logic         valid
);

    logic [N-1:0]   cand;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    int             off;
    int             sum;

    assign cand = req & mask;
    // Rotate so that bit 0 of rot corresponds to requester ptr.
    assign dbl  = {cand, cand} >> ptr;
    assign rot  = dbl[N-1:0];

    // Lowest set bit of the rotated vector, then undo the rotation.
    always_comb begin
        valid = 1'b0;
        off   = 0;
        sum   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                off   = k;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        idx = req_idx_t'(sum);
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign onehot[gi] = valid && (idx == req_idx_t'(gi));
        end
    endgenerate

endmodule

// File: rtl/our_sram_port_arbiter.sv
// Round-robin arbiter for the single SRAM port with bounded burst lock and tagged read return.
module our_sram_port_arbiter
    import our_sram_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic                          pll_core_cpuclk,
    input  logic                          pad_cpu_rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            lock_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] strb_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [DATA_WIDTH-1:0]         mem_wdata_o,
    output logic [DATA_WIDTH-1:0]         mem_strb_o,
    input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

    localparam int  HW       = $clog2(MAX_HOLD + 1);
    localparam bit  CAN_LOCK = (NUM_REQ > 1);

    arb_state_t         state_reg, state_next;
    req_idx_t           rr_ptr_reg, rr_ptr_next;
    req_idx_t           owner_reg, owner_next;
    logic [HW-1:0]      hold_cnt_reg, hold_cnt_next;
    logic               rd_vld_reg [RD_LATENCY];
    req_idx_t           rd_tag_reg [RD_LATENCY];

    logic [NUM_REQ-1:0] owner_oh;
    logic [NUM_REQ-1:0] pick_mask;
    logic [NUM_REQ-1:0] pick_oh;
    req_idx_t           pick_idx;
    logic               pick_valid;
    logic [NUM_REQ-1:0] gnt;
    req_idx_t           win_idx;
    logic               others_wait;
    logic               owner_req;
    logic               owner_lock;
    logic               rd_push;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_owner
            assign owner_oh[gi] = (owner_reg == req_idx_t'(gi));
        end
    endgenerate

    assign others_wait = |(req_i & ~owner_oh);
    assign owner_req   = |(req_i & owner_oh);
    assign owner_lock  = |(lock_i & owner_oh);
    // While locked the pick is only used for the forced hand-over, so the owner is excluded.
    assign pick_mask   = (state_reg == ARB_LOCKED) ? ~owner_oh : '1;

    our_rr_pick #(.N(NUM_REQ)) u_pick (
        .req    (req_i),
        .mask   (pick_mask),
        .ptr    (rr_ptr_reg),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Arbitration state, round-robin pointer, owner and hold counter.
    always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
        if (pad_cpu_rst) begin
            state_reg    <= ARB_OPEN;
            rr_ptr_reg   <= '0;
            owner_reg    <= '0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            owner_reg    <= owner_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // Grant selection and OPEN/LOCKED transitions.
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        owner_next    = owner_reg;
        hold_cnt_next = hold_cnt_reg;
        gnt           = '0;
        win_idx       = '0;
        // Round-robin grant: taken in OPEN, and when a locked owner has used up its hold budget.
        if (state_reg == ARB_OPEN ||
            (hold_cnt_reg >= HW'(MAX_HOLD) && others_wait)) begin
            gnt     = pick_oh;
            win_idx = pick_idx;
            if (state_reg == ARB_LOCKED) begin
                state_next    = ARB_OPEN;
                hold_cnt_next = '0;
            end
            if (pick_valid) begin
                rr_ptr_next = rr_next(pick_idx, NUM_REQ);
                if (CAN_LOCK && (|(lock_i & pick_oh))) begin
                    state_next    = ARB_LOCKED;
                    owner_next    = pick_idx;
                    hold_cnt_next = HW'(1);
                end
            end
        end else if (owner_req) begin
            // Owner keeps the port; a cycle without an owner request is left idle.
            gnt     = owner_oh;
            win_idx = owner_reg;
            if (!owner_lock) begin
                state_next    = ARB_OPEN;
                hold_cnt_next = '0;
            end else if (others_wait) begin
                hold_cnt_next = hold_cnt_reg + HW'(1);
            end
        end
    end

    assign gnt_o     = pad_cpu_rst ? '0 : gnt;
    assign mem_req_o = |gnt_o;
    assign mem_we_o  = |(gnt_o & we_i);
    assign rdata_o   = mem_rdata_i;
    assign rd_push   = mem_req_o & ~mem_we_o;

    // AND-OR mux of the granted requester's fields; all zero when nothing is granted.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_strb_o  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_o[i]) begin
                mem_addr_o  = mem_addr_o  | addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata_o = mem_wdata_o | wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                mem_strb_o  = mem_strb_o  | strb_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Read tag pipe: each granted read travels RD_LATENCY stages alongside the SRAM.
    always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
        if (pad_cpu_rst) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                rd_vld_reg[s] <= 1'b0;
                rd_tag_reg[s] <= '0;
            end
        end else begin
            rd_vld_reg[0] <= rd_push;
            rd_tag_reg[0] <= win_idx;
            for (int s = 1; s < RD_LATENCY; s++) begin
                rd_vld_reg[s] <= rd_vld_reg[s-1];
                rd_tag_reg[s] <= rd_tag_reg[s-1];
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rvalid
            assign rvalid_o[gi] = rd_vld_reg[RD_LATENCY-1] &&
                                  (rd_tag_reg[RD_LATENCY-1] == req_idx_t'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_our_sram_port_arbiter.sv
// Self-checking bench for our_sram_port_arbiter (2 requesters, read latency 2, hold limit 4).
module tb_our_sram_port_arbiter;

    localparam int NR  = 2;
    localparam int AW  = 21;
    localparam int DW  = 128;
    localparam int RDL = 2;
    localparam int MH  = 4;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_i, lock_i, we_i;
    logic [NR*AW-1:0]  addr_i;
    logic [NR*DW-1:0]  wdata_i, strb_i;
    logic [NR-1:0]     gnt_o, rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              mem_req_o, mem_we_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_wdata_o, mem_strb_o, mem_rdata_i;

    logic [AW-1:0]     tb_addr  [NR];
    logic [DW-1:0]     tb_wdata [NR];
    logic [DW-1:0]     tb_strb  [NR];

    typedef struct {
        int            due;
        logic [NR-1:0] oh;
    } rd_exp_t;
    rd_exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    our_sram_port_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (RDL),
        .MAX_HOLD   (MH)
    ) dut (
        .pll_core_cpuclk (clk),
        .pad_cpu_rst     (rst),
        .req_i           (req_i),
        .lock_i          (lock_i),
        .we_i            (we_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .strb_i          (strb_i),
        .gnt_o           (gnt_o),
        .rvalid_o        (rvalid_o),
        .rdata_o         (rdata_o),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_strb_o      (mem_strb_o),
        .mem_rdata_i     (mem_rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdata_pattern(input int c);
        return {4{32'(c) ^ 32'h5A5A_0000}};
    endfunction

    task automatic pack_inputs();
        for (int i = 0; i < NR; i++) begin
            addr_i[i*AW +: AW]  = tb_addr[i];
            wdata_i[i*DW +: DW] = tb_wdata[i];
            strb_i[i*DW +: DW]  = tb_strb[i];
        end
    endtask

    // One clock cycle: drive, check grant/port/read return mid-cycle, advance to 1 after next edge.
    task automatic step(input logic [NR-1:0] req, input logic [NR-1:0] lock,
                        input logic [NR-1:0] we, input logic [NR-1:0] exp_gnt);
        logic [NR-1:0] exp_rv;
        int            w;
        rd_exp_t       e;
        req_i       = req;
        lock_i      = lock;
        we_i        = we;
        pack_inputs();
        mem_rdata_i = rdata_pattern(cyc);
        #4;
        check_eq("gnt", DW'(gnt_o), DW'(exp_gnt));
        check_eq("mem_req", DW'(mem_req_o), DW'(|exp_gnt));
        if (exp_gnt != '0) begin
            w = exp_gnt[1] ? 1 : 0;
            check_eq("mem_addr", DW'(mem_addr_o), DW'(tb_addr[w]));
            check_eq("mem_we", DW'(mem_we_o), DW'(we[w]));
            if (we[w]) begin
                check_eq("mem_wdata", mem_wdata_o, tb_wdata[w]);
                check_eq("mem_strb", mem_strb_o, tb_strb[w]);
            end else begin
                e.due = cyc + RDL;
                e.oh  = exp_gnt;
                sb.push_back(e);
            end
        end
        exp_rv = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_rv = sb[0].oh;
            void'(sb.pop_front());
            check_eq("rdata", rdata_o, rdata_pattern(cyc));
        end
        check_eq("rvalid", DW'(rvalid_o), DW'(exp_rv));
        $display("cyc=%0d req=%b lock=%b we=%b gnt=%b rvalid=%b addr=%h",
                 cyc, req, lock, we, gnt_o, rvalid_o, mem_addr_o);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst         = 1'b1;
        req_i       = 2'b11;
        lock_i      = '0;
        we_i        = '0;
        tb_addr[0]  = 21'h00020;
        tb_addr[1]  = 21'h00010;
        tb_wdata[0] = {4{32'h1111_0000}};
        tb_wdata[1] = {4{32'h2222_0000}};
        tb_strb[0]  = '0;
        tb_strb[1]  = '0;
        pack_inputs();
        mem_rdata_i = '0;

        // Reset holds everything quiet even with both requesting.
        @(posedge clk);
        #5;
        check_eq("rst_gnt", DW'(gnt_o), '0);
        check_eq("rst_mem_req", DW'(mem_req_o), '0);
        check_eq("rst_mem_we", DW'(mem_we_o), '0);
        check_eq("rst_rvalid", DW'(rvalid_o), '0);
        check_eq("rst_mem_addr", DW'(mem_addr_o), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fairness: strict alternation starting at requester 0 (back-to-back reads).
        for (int i = 0; i < 6; i++) begin
            step(2'b11, 2'b00, 2'b00, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        step(2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00, 2'b00);

        // Read tag: req1 then req0, data returns tagged two cycles after each grant.
        step(2'b10, 2'b00, 2'b00, 2'b10);
        step(2'b01, 2'b00, 2'b00, 2'b01);
        step(2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00, 2'b00);

        // Lock/starvation: req0 locked, req1 waiting -> four grants to 0, then one to 1.
        step(2'b01, 2'b01, 2'b00, 2'b01);
        for (int i = 0; i < MH - 1; i++) begin
            step(2'b11, 2'b01, 2'b00, 2'b01);
        end
        step(2'b11, 2'b01, 2'b00, 2'b10);
        step(2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00, 2'b00);

        // Write pass-through at the top address, full mask; no read return.
        tb_addr[0]  = 21'h1F_FFFF;
        tb_wdata[0] = {16{8'hA5}};
        tb_strb[0]  = '1;
        step(2'b01, 2'b00, 2'b01, 2'b01);
        step(2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00, 2'b00);

        // Reset mid-read: the in-flight tag must never come back.
        step(2'b10, 2'b00, 2'b00, 2'b10);
        rst   = 1'b1;
        req_i = 2'b11;
        #4;
        check_eq("midrst_gnt", DW'(gnt_o), '0);
        check_eq("midrst_mem_req", DW'(mem_req_o), '0);
        check_eq("midrst_rvalid", DW'(rvalid_o), '0);
        sb.delete();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        step(2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00, 2'b00);

        // After reset the pointer is back at requester 0.
        step(2'b11, 2'b00, 2'b00, 2'b01);
        step(2'b00, 2'b00, 2'b00, 2'b00);
        step(2'b00, 2'b00, 2'b00, 2'b00);

        check_eq("sb_drained", DW'(sb.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
